// File: rtl/kernel_apply.sv
// kernel_apply
//   Applies a latched Q0.8 convolution kernel to incoming pixel windows.
//   The kernel is captured on the kernel builder's done pulse (kernel_valid).
//   Each accepted window is then convolved with one multiply-accumulate per
//   cycle, and one saturated 8-bit result is returned per window over a
//   valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   kernel       normalized kernel, Q0.8 unsigned, indexed [y][x]
//   kernel_size  active edge length n, sampled with kernel_valid
//   kernel_valid one-cycle pulse qualifying kernel/kernel_size
//   window       pixel window, indexed [y][x]
//   win_valid    window valid (source holds it until accepted)
//   win_ready    high while a window can be accepted
//   pix_out      filtered pixel
//   pix_valid    pix_out valid
//   out_ready    downstream accepts pix_out
//   busy         high while convolving or holding a result
//   err          sticky flag: an illegal kernel_size was received
//
// Configuration
//   KERNEL_APPLY_ROUND_EN  defined: round half up before saturation;
//                          undefined: truncate before saturation.

module kernel_apply #(
  parameter int MAX_KERNAL = 3
) (
  input  logic                                      clk,
  input  logic                                      n_rst,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kernel,
  input  logic [$clog2(MAX_KERNAL)-1:0]             kernel_size,
  input  logic                                      kernel_valid,
  input  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] window,
  input  logic                                      win_valid,
  output logic                                      win_ready,
  output logic [7:0]                                pix_out,
  output logic                                      pix_valid,
  input  logic                                      out_ready,
  output logic                                      busy,
  output logic                                      err
);

  localparam int SW    = $clog2(MAX_KERNAL);
  localparam int ACC_W = 16 + $clog2(MAX_KERNAL * MAX_KERNAL) + 1;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    MAC,
    OUT
  } state_t;

  state_t state;

  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kern_act;
  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] kern_pend;
  logic [MAX_KERNAL-1:0][MAX_KERNAL-1:0][7:0] win_reg;
  logic [SW-1:0]                             size_act;
  logic [SW-1:0]                             size_pend;
  logic                                      pend;
  logic [ACC_W-1:0]                          acc;
  logic [SW-1:0]                             x;
  logic [SW-1:0]                             y;
  logic                                      mac_last;

  logic                                      size_ok;
  logic                                      load_ok;
  logic [SW-1:0]                             last_idx;
  logic [15:0]                               prod;
  logic [ACC_W:0]                            sum;
  logic [7:0]                                result;

  assign win_ready = (state == READY);
  assign busy      = (state == MAC) || (state == OUT);

  // Legal edge lengths are 1..MAX_KERNAL; the extra zero bit keeps the
  // comparison wide enough to hold MAX_KERNAL itself.
  assign size_ok  = (kernel_size != '0) &&
                    ({1'b0, kernel_size} <= (SW + 1)'(MAX_KERNAL));
  assign load_ok  = kernel_valid && size_ok;
  assign last_idx = size_act - 1'b1;
  assign prod     = win_reg[y][x] * kern_act[y][x];

  // Output scaling from the Q0.8 accumulator back to 8-bit pixels. Any bit
  // above the 8-bit result field means the pixel would exceed 255.
  always_comb begin
    sum    = '0;
    result = '0;
`ifdef KERNEL_APPLY_ROUND_EN
    sum = {1'b0, acc} + (ACC_W + 1)'(128);
`else
    sum = {1'b0, acc};
`endif
    if (|sum[ACC_W:16]) begin
      result = 8'hFF;
    end else begin
      result = sum[15:8];
    end
  end

  // Control and datapath. Kernel loads are handled first; the state case
  // below may override pending bookkeeping on the OUT->READY edge, where a
  // load arriving in the same cycle is the newest kernel and wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      kern_act  <= '0;
      kern_pend <= '0;
      win_reg   <= '0;
      size_act  <= '0;
      size_pend <= '0;
      pend      <= 1'b0;
      acc       <= '0;
      x         <= '0;
      y         <= '0;
      mac_last  <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (kernel_valid) begin
        if (!size_ok) begin
          err <= 1'b1;
        end else begin
          err <= 1'b0;
          if (state == IDLE || state == READY) begin
            kern_act <= kernel;
            size_act <= kernel_size;
            state    <= READY;
          end else begin
            kern_pend <= kernel;
            size_pend <= kernel_size;
            pend      <= 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
        end

        // A kernel pulse in the same cycle blocks the accept so the window
        // is always convolved with a settled kernel.
        READY: begin
          if (win_valid && !kernel_valid) begin
            win_reg  <= window;
            acc      <= '0;
            x        <= '0;
            y        <= '0;
            mac_last <= 1'b0;
            state    <= MAC;
          end
        end

        // n*n accumulate edges, then one extra edge to register the result.
        MAC: begin
          if (!mac_last) begin
            acc <= acc + ACC_W'(prod);
            if (x == last_idx) begin
              x <= '0;
              if (y == last_idx) begin
                mac_last <= 1'b1;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end else begin
            pix_out   <= result;
            pix_valid <= 1'b1;
            state     <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            pix_valid <= 1'b0;
            state     <= READY;
            if (load_ok) begin
              kern_act <= kernel;
              size_act <= kernel_size;
              pend     <= 1'b0;
            end else if (pend) begin
              kern_act <= kern_pend;
              size_act <= size_pend;
              pend     <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_apply.sv
// tb_kernel_apply
//   Directed bench for kernel_apply with hand-computed expected pixels.

module tb_kernel_apply;

  logic                   clk;
  logic                   n_rst;
  logic [2:0][2:0][7:0]   kernel;
  logic [1:0]             kernel_size;
  logic                   kernel_valid;
  logic [2:0][2:0][7:0]   window;
  logic                   win_valid;
  logic                   win_ready;
  logic [7:0]             pix_out;
  logic                   pix_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   err;

  int checks;
  int errors;

  logic [2:0][2:0][7:0]   next_k;
  logic [1:0]             next_n;

`ifdef KERNEL_APPLY_ROUND_EN
  localparam logic [7:0] EXP_AVG = 8'd197;
`else
  localparam logic [7:0] EXP_AVG = 8'd196;
`endif

  kernel_apply #(.MAX_KERNAL(3)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .kernel       (kernel),
    .kernel_size  (kernel_size),
    .kernel_valid (kernel_valid),
    .window       (window),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .pix_out      (pix_out),
    .pix_valid    (pix_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Fill a 3x3 array with one value.
  function automatic logic [2:0][2:0][7:0] fill(input logic [7:0] v);
    logic [2:0][2:0][7:0] a;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        a[i][j] = v;
    return a;
  endfunction

  // Pulse kernel_valid for one cycle with the given kernel and size.
  task automatic applyStimulus(input logic [2:0][2:0][7:0] k, input logic [1:0] n);
    @(negedge clk);
    kernel       = k;
    kernel_size  = n;
    kernel_valid = 1'b1;
    @(negedge clk);
    kernel_valid = 1'b0;
  endtask

  // Present a window, measure latency from the accept edge, optionally hold
  // off the output and/or pulse a new kernel during MAC, then check result.
  task automatic runWindow(input string tag, input logic [2:0][2:0][7:0] w,
                           input logic [7:0] exp_pix, input int exp_lat,
                           input int hold, input bit mid_load);
    int  lat;
    bit  stable;
    logic [7:0] held;
    @(negedge clk);
    window    = w;
    win_valid = 1'b1;
    out_ready = (hold == 0);
    checkOutput({tag, "_ready"}, win_ready, 1);
    @(posedge clk);
    #1 win_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (mid_load && lat == 3) begin
        kernel       = next_k;
        kernel_size  = next_n;
        kernel_valid = 1'b1;
      end else begin
        kernel_valid = 1'b0;
      end
      if (lat == 1) checkOutput({tag, "_busy"}, busy, 1);
      if (pix_valid) break;
    end
    kernel_valid = 1'b0;
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_pix"}, pix_out, exp_pix);
    held   = pix_out;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!pix_valid || pix_out !== held) stable = 1'b0;
    end
    if (hold > 0) checkOutput({tag, "_hold_stable"}, stable, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, pix_valid, 0);
    checkOutput({tag, "_back_ready"}, win_ready, 1);
  endtask

  initial begin
    logic [2:0][2:0][7:0] k;
    logic [2:0][2:0][7:0] w;
    bit saw_ready;
    bit saw_valid;

    checks       = 0;
    errors       = 0;
    n_rst        = 1'b0;
    kernel       = '0;
    kernel_size  = '0;
    kernel_valid = 1'b0;
    window       = '0;
    win_valid    = 1'b0;
    out_ready    = 1'b1;
    next_k       = '0;
    next_n       = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_pix_out", pix_out, 0);
    checkOutput("rst_pix_valid", pix_valid, 0);
    checkOutput("rst_win_ready", win_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    n_rst = 1'b1;

    // No kernel loaded: windows must never be accepted.
    win_valid = 1'b1;
    window    = fill(8'd100);
    saw_ready = 1'b0;
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (win_ready) saw_ready = 1'b1;
      if (pix_valid) saw_valid = 1'b1;
    end
    win_valid = 1'b0;
    checkOutput("idle_no_ready", saw_ready, 0);
    checkOutput("idle_no_valid", saw_valid, 0);
    checkOutput("idle_err", err, 0);

    // Uniform kernel, uniform window: 9*200*28 = 50400.
    applyStimulus(fill(8'd28), 2'd3);
    checkOutput("load_err", err, 0);
    runWindow("avg", fill(8'd200), EXP_AVG, 10, 0, 1'b0);

    // Identity kernel: 200*255 = 51000 -> 199 either way.
    k = '0; k[1][1] = 8'd255;
    applyStimulus(k, 2'd3);
    w = fill(8'd50); w[1][1] = 8'd200;
    runWindow("ident", w, 8'd199, 10, 0, 1'b0);

    // 9*255*255 = 585225 saturates.
    applyStimulus(fill(8'd255), 2'd3);
    runWindow("sat", fill(8'd255), 8'd255, 10, 0, 1'b0);

    // n=2: only the top-left 2x2 is used; outer entries are 255.
    k = fill(8'd255);
    k[0][0] = 8'd64; k[0][1] = 8'd64; k[1][0] = 8'd64; k[1][1] = 8'd64;
    applyStimulus(k, 2'd2);
    w = fill(8'd255);
    w[0][0] = 8'd100; w[0][1] = 8'd100; w[1][0] = 8'd100; w[1][1] = 8'd100;
    runWindow("n2", w, 8'd100, 5, 0, 1'b0);

    // Backpressure plus a kernel load during MAC: the in-flight window keeps
    // the identity kernel, the next one sees the uniform 28 kernel.
    k = '0; k[1][1] = 8'd255;
    applyStimulus(k, 2'd3);
    next_k = fill(8'd28);
    next_n = 2'd3;
    w = fill(8'd50); w[1][1] = 8'd200;
    runWindow("hold_old", w, 8'd199, 10, 6, 1'b1);
    runWindow("pend_new", fill(8'd200), EXP_AVG, 10, 0, 1'b0);

    // Illegal size sets err without disturbing state; legal load clears it.
    applyStimulus(fill(8'd1), 2'd0);
    checkOutput("bad_err", err, 1);
    checkOutput("bad_ready", win_ready, 1);
    checkOutput("bad_busy", busy, 0);
    runWindow("bad_keep", fill(8'd200), EXP_AVG, 10, 0, 1'b0);
    applyStimulus(fill(8'd28), 2'd3);
    checkOutput("good_err", err, 0);

    // Reset mid-MAC drops everything back to IDLE.
    @(negedge clk);
    window    = fill(8'd200);
    win_valid = 1'b1;
    @(posedge clk);
    #1 win_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    checkOutput("mrst_pix_out", pix_out, 0);
    checkOutput("mrst_pix_valid", pix_valid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_win_ready", win_ready, 0);
    checkOutput("mrst_err", err, 0);
    @(negedge clk);
    n_rst     = 1'b1;
    win_valid = 1'b1;
    saw_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (win_ready) saw_ready = 1'b1;
    end
    win_valid = 1'b0;
    checkOutput("mrst_idle", saw_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
